// File: rtl/joy_conditioner.sv
// Joystick button conditioner: per-bit debounce, SOCD cleaning, autofire on fire3,
// optional port swap, and Minimig active-low joystick bus generation.
module joy_conditioner #(
   parameter int TICK_DIV = 28000,
   parameter int DB_TICKS = 4,
   parameter int AF_HALF  = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] joy1_in,
   input  logic [7:0] joy2_in,
   input  logic [1:0] af_en,
   input  logic       swap,
   output logic [7:0] joy1_out,
   output logic [7:0] joy2_out,
   output logic [5:0] joy1_n,
   output logic [5:0] joy2_n,
   output logic       changed
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [3:0]    DB_LAST   = 4'(DB_TICKS - 1);
   localparam logic [7:0]    AF_LAST   = 8'(AF_HALF - 1);

   localparam int B_UP = 7;
   localparam int B_DN = 6;
   localparam int B_LT = 5;
   localparam int B_RT = 4;
   localparam int B_F1 = 3;
   localparam int B_F3 = 1;

   logic [15:0]        sample_q;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic               tick;
   logic [15:0][3:0]   db_cnt_q, db_cnt_d;
   logic [15:0]        deb_q, deb_d;
   logic [1:0]         phase_q, phase_d;
   logic [1:0][7:0]    af_cnt_q, af_cnt_d;
   logic [7:0]         cond1, cond2;
   logic [7:0]         joy1_out_q, joy1_out_d;
   logic [7:0]         joy2_out_q, joy2_out_d;
   logic               changed_q, changed_d;

   function automatic logic [7:0] socd(input logic [7:0] v);
      logic [7:0] r;
      r = v;
      if (v[B_UP] && v[B_DN]) begin
         r[B_UP] = 1'b0;
         r[B_DN] = 1'b0;
      end
      if (v[B_LT] && v[B_RT]) begin
         r[B_LT] = 1'b0;
         r[B_RT] = 1'b0;
      end
      return r;
   endfunction

   // Stage 0: raw input capture
   always_ff @(posedge clk) begin
      sample_q <= {joy2_in, joy1_in};
   end

   // Stage 1: tick, debounce and autofire state
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 16; i++) begin
         if (sample_q[i] == deb_q[i]) begin
            db_cnt_d[i] = 4'd0;
         end else if (tick) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i]    = sample_q[i];
               db_cnt_d[i] = 4'd0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 4'd1;
            end
         end
      end

      phase_d  = phase_q;
      af_cnt_d = af_cnt_q;
      for (int p = 0; p < 2; p++) begin
         // Rising fire3 is checked before tick expiry: the restart wins.
         if (!af_en[p] || !deb_d[p*8+B_F3]) begin
            phase_d[p]  = 1'b0;
            af_cnt_d[p] = 8'd0;
         end else if (!deb_q[p*8+B_F3]) begin
            phase_d[p]  = 1'b1;
            af_cnt_d[p] = 8'd0;
         end else if (tick) begin
            if (af_cnt_q[p] == AF_LAST) begin
               phase_d[p]  = ~phase_q[p];
               af_cnt_d[p] = 8'd0;
            end else begin
               af_cnt_d[p] = af_cnt_q[p] + 8'd1;
            end
         end
      end

      cond1        = socd(deb_q[7:0]);
      cond1[B_F1]  = cond1[B_F1] | phase_q[0];
      cond2        = socd(deb_q[15:8]);
      cond2[B_F1]  = cond2[B_F1] | phase_q[1];

      joy1_out_d = swap ? cond2 : cond1;
      joy2_out_d = swap ? cond1 : cond2;
      changed_d  = ({joy2_out_d, joy1_out_d} != {joy2_out_q, joy1_out_q});
   end

   // Stage 2: output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
         db_cnt_q   <= '0;
         deb_q      <= '0;
         phase_q    <= '0;
         af_cnt_q   <= '0;
         joy1_out_q <= '0;
         joy2_out_q <= '0;
         changed_q  <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         db_cnt_q   <= db_cnt_d;
         deb_q      <= deb_d;
         phase_q    <= phase_d;
         af_cnt_q   <= af_cnt_d;
         joy1_out_q <= joy1_out_d;
         joy2_out_q <= joy2_out_d;
         changed_q  <= changed_d;
      end
   end

   assign joy1_out = joy1_out_q;
   assign joy2_out = joy2_out_q;
   assign joy1_n   = ~{joy1_out_q[2], joy1_out_q[3], joy1_out_q[7:4]};
   assign joy2_n   = ~{joy2_out_q[2], joy2_out_q[3], joy2_out_q[7:4]};
   assign changed  = changed_q;

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed bench for joy_conditioner with TICK_DIV=4, DB_TICKS=3, AF_HALF=2.
// Edge counter e counts clk edges since the last reset edge; ticks land on e = 4, 8, 12, ...
module tb_joy_conditioner;

   logic       clk;
   logic       rst_n;
   logic [7:0] joy1_in;
   logic [7:0] joy2_in;
   logic [1:0] af_en;
   logic       swap;
   logic [7:0] joy1_out;
   logic [7:0] joy2_out;
   logic [5:0] joy1_n;
   logic [5:0] joy2_n;
   logic       changed;

   int checks = 0;
   int errors = 0;
   int e = 0;

   joy_conditioner #(
      .TICK_DIV(4),
      .DB_TICKS(3),
      .AF_HALF (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .joy1_in (joy1_in),
      .joy2_in (joy2_in),
      .af_en   (af_en),
      .swap    (swap),
      .joy1_out(joy1_out),
      .joy2_out(joy2_out),
      .joy1_n  (joy1_n),
      .joy2_n  (joy2_n),
      .changed (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      joy1_in = 8'h00;
      joy2_in = 8'h00;
      af_en   = 2'b00;
      swap    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      e     = 0;
   endtask

   task automatic adv_to(input int k);
      while (e < k) begin
         @(posedge clk);
         e++;
      end
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({joy2_out, joy1_out} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_out: got %h expected 0000", {joy2_out, joy1_out});
      end
      checks++;
      if ({joy2_n, joy1_n} !== 12'hFFF) begin
         errors++;
         $display("FAIL reset_n: got %h expected fff", {joy2_n, joy1_n});
      end
      checks++;
      if (changed !== 1'b0) begin
         errors++;
         $display("FAIL reset_changed: got %b expected 0", changed);
      end
   endtask

   task automatic test_idle();
      int bad;
      do_reset();
      bad = 0;
      for (int k = 1; k <= 24; k++) begin
         adv_to(k);
         if (changed !== 1'b0 || joy1_n !== 6'h3F || joy2_n !== 6'h3F ||
             joy1_out !== 8'h00 || joy2_out !== 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_debounce_accept();
      do_reset();
      joy1_in = 8'h80;
      adv_to(12);
      checks++;
      if (joy1_out !== 8'h00) begin
         errors++;
         $display("FAIL accept_early: got %h expected 00", joy1_out);
      end
      adv_to(13);
      checks++;
      if (joy1_out !== 8'h80 || joy1_n !== 6'b110111) begin
         errors++;
         $display("FAIL accept_out: got %h/%b expected 80/110111", joy1_out, joy1_n);
      end
      checks++;
      if (changed !== 1'b1) begin
         errors++;
         $display("FAIL accept_changed: got %b expected 1", changed);
      end
      adv_to(14);
      checks++;
      if (changed !== 1'b0 || joy1_out !== 8'h80) begin
         errors++;
         $display("FAIL accept_hold: got %b/%h expected 0/80", changed, joy1_out);
      end
   endtask

   task automatic test_glitch();
      int bad;
      do_reset();
      joy2_in = 8'h10;
      adv_to(8);
      joy2_in = 8'h00;
      bad = 0;
      for (int k = 9; k <= 24; k++) begin
         adv_to(k);
         if (joy2_out !== 8'h00 || joy2_n !== 6'h3F || changed !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL glitch: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_socd();
      do_reset();
      joy1_in = 8'hC0;
      adv_to(13);
      checks++;
      if (joy1_out !== 8'h00 || joy1_n !== 6'h3F || changed !== 1'b0) begin
         errors++;
         $display("FAIL socd_cancel: got %h/%h/%b expected 00/3f/0", joy1_out, joy1_n, changed);
      end
      adv_to(14);
      joy1_in = 8'h80;
      adv_to(24);
      checks++;
      if (joy1_out !== 8'h00) begin
         errors++;
         $display("FAIL socd_release_early: got %h expected 00", joy1_out);
      end
      adv_to(25);
      checks++;
      if (joy1_out !== 8'h80 || changed !== 1'b1) begin
         errors++;
         $display("FAIL socd_release: got %h/%b expected 80/1", joy1_out, changed);
      end
   endtask

   task automatic test_autofire();
      do_reset();
      af_en   = 2'b01;
      joy1_in = 8'h02;
      adv_to(13);
      checks++;
      if (joy1_out !== 8'h0A || joy1_n !== 6'h2F) begin
         errors++;
         $display("FAIL af_start: got %h/%h expected 0a/2f", joy1_out, joy1_n);
      end
      adv_to(20);
      checks++;
      if (joy1_out !== 8'h0A) begin
         errors++;
         $display("FAIL af_high_hold: got %h expected 0a", joy1_out);
      end
      adv_to(21);
      checks++;
      if (joy1_out !== 8'h02 || changed !== 1'b1) begin
         errors++;
         $display("FAIL af_low: got %h/%b expected 02/1", joy1_out, changed);
      end
      adv_to(28);
      checks++;
      if (joy1_out !== 8'h02) begin
         errors++;
         $display("FAIL af_low_hold: got %h expected 02", joy1_out);
      end
      adv_to(29);
      checks++;
      if (joy1_out !== 8'h0A) begin
         errors++;
         $display("FAIL af_high2: got %h expected 0a", joy1_out);
      end
      adv_to(37);
      checks++;
      if (joy1_out !== 8'h02) begin
         errors++;
         $display("FAIL af_low2: got %h expected 02", joy1_out);
      end
      joy1_in = 8'h00;
      adv_to(48);
      checks++;
      if (joy1_out !== 8'h0A) begin
         errors++;
         $display("FAIL af_before_release: got %h expected 0a", joy1_out);
      end
      adv_to(49);
      checks++;
      if (joy1_out !== 8'h00 || joy1_n !== 6'h3F) begin
         errors++;
         $display("FAIL af_release: got %h/%h expected 00/3f", joy1_out, joy1_n);
      end

      do_reset();
      joy1_in = 8'h02;
      adv_to(13);
      checks++;
      if (joy1_out !== 8'h02) begin
         errors++;
         $display("FAIL af_off_a: got %h expected 02", joy1_out);
      end
      adv_to(21);
      checks++;
      if (joy1_out !== 8'h02) begin
         errors++;
         $display("FAIL af_off_b: got %h expected 02", joy1_out);
      end
      adv_to(29);
      checks++;
      if (joy1_out !== 8'h02 || joy1_n !== 6'h3F) begin
         errors++;
         $display("FAIL af_off_c: got %h/%h expected 02/3f", joy1_out, joy1_n);
      end
   endtask

   task automatic test_swap_and_reset();
      do_reset();
      joy1_in = 8'h80;
      adv_to(16);
      checks++;
      if (joy1_out !== 8'h80 || joy2_out !== 8'h00) begin
         errors++;
         $display("FAIL swap_before: got %h/%h expected 80/00", joy1_out, joy2_out);
      end
      swap = 1'b1;
      adv_to(17);
      checks++;
      if (joy2_out !== 8'h80 || joy2_n !== 6'b110111 || joy1_out !== 8'h00 || joy1_n !== 6'h3F) begin
         errors++;
         $display("FAIL swap_out: got %h/%b %h/%h expected 80/110111 00/3f",
                  joy2_out, joy2_n, joy1_out, joy1_n);
      end
      checks++;
      if (changed !== 1'b1) begin
         errors++;
         $display("FAIL swap_changed: got %b expected 1", changed);
      end
      adv_to(18);
      checks++;
      if (changed !== 1'b0) begin
         errors++;
         $display("FAIL swap_changed_once: got %b expected 0", changed);
      end
      rst_n = 1'b0;
      adv_to(19);
      checks++;
      if ({joy2_out, joy1_out} !== 16'h0000 || {joy2_n, joy1_n} !== 12'hFFF || changed !== 1'b0) begin
         errors++;
         $display("FAIL midstream_reset: got %h/%h/%b expected 0000/fff/0",
                  {joy2_out, joy1_out}, {joy2_n, joy1_n}, changed);
      end
      rst_n = 1'b1;
      swap  = 1'b0;
   endtask

   task automatic test_reset_discards();
      do_reset();
      joy1_in = 8'h80;
      adv_to(9);
      rst_n = 1'b0;
      adv_to(10);
      rst_n = 1'b1;
      e     = 0;
      adv_to(12);
      checks++;
      if (joy1_out !== 8'h00) begin
         errors++;
         $display("FAIL discard_early: got %h expected 00", joy1_out);
      end
      adv_to(13);
      checks++;
      if (joy1_out !== 8'h80) begin
         errors++;
         $display("FAIL discard_accept: got %h expected 80", joy1_out);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      joy1_in = 8'h00;
      joy2_in = 8'h00;
      af_en   = 2'b00;
      swap    = 1'b0;
      test_reset();
      test_idle();
      test_debounce_accept();
      test_glitch();
      test_socd();
      test_autofire();
      test_swap_and_reset();
      test_reset_discards();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
